// File: rtl/am2940_pkg.sv
// Shared definitions for the am2940 DMA sequencer: instruction codes,
// control-register bit positions and sequencer states.
package am2940_pkg;

  typedef enum logic [2:0] {
    WRCR   = 3'd0,
    RDCR   = 3'd1,
    RDWC   = 3'd2,
    RDAC   = 3'd3,
    REINIT = 3'd4,
    LDADDR = 3'd5,
    LDWC   = 3'd6,
    ENCT   = 3'd7
  } am2940_instr_e;

  localparam int unsigned CR_MODE_LSB = 0;
  localparam int unsigned CR_MODE_MSB = 1;
  localparam int unsigned CR_DEC_BIT  = 2;
  localparam int unsigned CR_W        = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_CR,
    ST_LD_ADDR,
    ST_LD_WC,
    ST_RB_ADDR,
    ST_RB_WC,
    ST_RUN,
    ST_STEP,
    ST_CPL
  } seq_state_e;

endpackage

// File: rtl/am2940_beat_ctr.sv
// Saturating beat counter with clear/increment, compared against the
// expected beat total (match) and flagged once it runs past it (over).
module am2940_beat_ctr #(
  parameter int unsigned CW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] expected,
  output logic [CW-1:0] count,
  output logic          match,
  output logic          over
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign match = (count_q == expected);
  assign over  = (count_q > expected);

endmodule

// File: rtl/am2940_dma_sequencer.sv
// Initiator-side sequencer that programs an am2940 and steps it per memory beat.
// Optional readback verification of programmed registers: AM2940_SEQ_READBACK_EN.
module am2940_dma_sequencer
  import am2940_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_count,
  input  logic [1:0]    req_mode,
  input  logic          req_dec,
  output logic [2:0]    instr,
  output logic [AW-1:0] dev_datain,
  input  logic [AW-1:0] dev_dataout,
  input  logic          dev_oedata,
  input  logic [AW-1:0] dev_address,
  output logic          cina,
  output logic          cinw,
  input  logic          done,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  output logic          busy,
  output logic          cpl_valid,
  output logic          cpl_err,
  output logic [CW-1:0] cpl_beats
);

  localparam logic [CW-1:0] FULL_COUNT = {{(CW-1){1'b0}}, 1'b1} << AW;

  seq_state_e    state_q, state_d;
  am2940_instr_e instr_q, instr_d;
  logic [AW-1:0] datain_q, datain_d;
  logic          cina_q, cina_d;
  logic          mem_req_q, mem_req_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic          cpl_valid_q, cpl_valid_d;
  logic          cpl_err_q, cpl_err_d;
  logic [CW-1:0] cpl_beats_q, cpl_beats_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] count_q, count_d;
  logic [CR_W-1:0] cr_q, cr_d;
  logic [CW-1:0] expected_q, expected_d;

  logic          ctr_clr, ctr_inc, ctr_match, ctr_over;
  logic [CW-1:0] ctr_count;

`ifdef AM2940_SEQ_READBACK_EN
  logic [1:0]    rb_wait_q, rb_wait_d;
  logic [AW-1:0] rb_ref;
`else
  logic unused_rb;
  assign unused_rb = ^{dev_dataout, dev_oedata};
`endif

  am2940_beat_ctr #(.CW(CW)) u_beat_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr      (ctr_clr),
    .inc      (ctr_inc),
    .expected (expected_q),
    .count    (ctr_count),
    .match    (ctr_match),
    .over     (ctr_over)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    cr_d        = cr_q;
    expected_d  = expected_q;
    cpl_err_d   = cpl_err_q;
    cpl_beats_d = cpl_beats_q;
    ctr_clr     = 1'b0;
    ctr_inc     = 1'b0;
`ifdef AM2940_SEQ_READBACK_EN
    rb_wait_d   = rb_wait_q;
    rb_ref      = (state_q == ST_RB_ADDR) ? addr_q : count_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          addr_d                          = req_addr;
          count_d                         = req_count;
          cr_d                            = '0;
          cr_d[CR_MODE_MSB:CR_MODE_LSB]   = req_mode;
          cr_d[CR_DEC_BIT]                = req_dec;
          expected_d = (req_count == '0) ? FULL_COUNT : CW'(req_count);
          ctr_clr    = 1'b1;
          state_d    = ST_WR_CR;
        end
      end
      ST_WR_CR:   state_d = ST_LD_ADDR;
      ST_LD_ADDR: state_d = ST_LD_WC;
`ifdef AM2940_SEQ_READBACK_EN
      ST_LD_WC: begin
        rb_wait_d = '0;
        state_d   = ST_RB_ADDR;
      end
      ST_RB_ADDR, ST_RB_WC: begin
        if (dev_oedata && (dev_dataout == rb_ref)) begin
          rb_wait_d = '0;
          state_d   = (state_q == ST_RB_ADDR) ? ST_RB_WC : ST_RUN;
        end else if (dev_oedata || (rb_wait_q == 2'd3)) begin
          rb_wait_d   = '0;
          cpl_err_d   = 1'b1;
          cpl_beats_d = '0;
          state_d     = ST_CPL;
        end else begin
          rb_wait_d = rb_wait_q + 2'd1;
        end
      end
`else
      ST_LD_WC:   state_d = ST_RUN;
`endif
      // A beat wins over done; done is only trusted once the bus is idle.
      ST_RUN: begin
        if (mem_req_q && mem_ack) begin
          ctr_inc = 1'b1;
          state_d = ST_STEP;
        end else if (mem_req_q && done) begin
          cpl_err_d   = ~ctr_match;
          cpl_beats_d = ctr_count;
          state_d     = ST_CPL;
        end
      end
      ST_STEP: begin
        if (ctr_over) begin
          cpl_err_d   = 1'b1;
          cpl_beats_d = ctr_count;
          state_d     = ST_CPL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_CPL:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    instr_d     = RDCR;
    datain_d    = '0;
    cina_d      = 1'b0;
    mem_req_d   = 1'b0;
    cpl_valid_d = 1'b0;
    busy_d      = (state_d != ST_IDLE);
    ready_d     = (state_d == ST_IDLE);
    unique case (state_d)
      ST_WR_CR: begin
        instr_d  = WRCR;
        datain_d = AW'(cr_d);
      end
      ST_LD_ADDR: begin
        instr_d  = LDADDR;
        datain_d = addr_d;
      end
      ST_LD_WC: begin
        instr_d  = LDWC;
        datain_d = count_d;
      end
      ST_RB_ADDR: instr_d = RDAC;
      ST_RB_WC:   instr_d = RDWC;
      ST_RUN: begin
        instr_d   = ENCT;
        mem_req_d = 1'b1;
      end
      ST_STEP: begin
        instr_d = ENCT;
        cina_d  = 1'b1;
      end
      ST_CPL:  cpl_valid_d = 1'b1;
      default: instr_d = RDCR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      instr_q     <= RDCR;
      datain_q    <= '0;
      cina_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      cpl_valid_q <= 1'b0;
      cpl_err_q   <= 1'b0;
      cpl_beats_q <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      cr_q        <= '0;
      expected_q  <= '0;
`ifdef AM2940_SEQ_READBACK_EN
      rb_wait_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      datain_q    <= datain_d;
      cina_q      <= cina_d;
      mem_req_q   <= mem_req_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_err_q   <= cpl_err_d;
      cpl_beats_q <= cpl_beats_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      cr_q        <= cr_d;
      expected_q  <= expected_d;
`ifdef AM2940_SEQ_READBACK_EN
      rb_wait_q   <= rb_wait_d;
`endif
    end
  end

  assign instr      = instr_q;
  assign dev_datain = datain_q;
  assign cina       = cina_q;
  assign cinw       = cina_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = dev_address;
  assign busy       = busy_q;
  assign req_ready  = ready_q;
  assign cpl_valid  = cpl_valid_q;
  assign cpl_err    = cpl_err_q;
  assign cpl_beats  = cpl_beats_q;

endmodule

// File: tb/tb_am2940_dma_sequencer.sv
// Directed self-checking bench for am2940_dma_sequencer with a small am2940
// behavioural model and a memory responder.
module tb_am2940_dma_sequencer;
  import am2940_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_dec;
  logic [7:0] req_addr, req_count;
  logic [1:0] req_mode;
  logic [2:0] instr;
  logic [7:0] dev_datain, dev_dataout, dev_address, mem_addr;
  logic       dev_oedata, cina, cinw, done, mem_req, mem_ack;
  logic       busy, cpl_valid, cpl_err;
  logic [8:0] cpl_beats;

  int n_checks = 0;
  int n_fail   = 0;

  am2940_dma_sequencer #(.AW(8), .CW(9)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_count(req_count), .req_mode(req_mode),
    .req_dec(req_dec), .instr(instr), .dev_datain(dev_datain),
    .dev_dataout(dev_dataout), .dev_oedata(dev_oedata),
    .dev_address(dev_address), .cina(cina), .cinw(cinw), .done(done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .busy(busy), .cpl_valid(cpl_valid), .cpl_err(cpl_err),
    .cpl_beats(cpl_beats)
  );

  always #5 clk = ~clk;

  // am2940 model: loads registers per instruction, counts on cina/cinw.
  logic [7:0] m_addr, m_wc;
  logic [2:0] m_cr;
  int         m_steps = 0;
  int         done_after = 0;
  bit         done_en = 1'b0;
  logic [7:0] wc_corrupt = 8'h00;

  always @(posedge clk) begin
    if (instr == WRCR)   m_cr <= dev_datain[2:0];
    if (instr == LDADDR) m_addr <= dev_datain;
    if (instr == LDWC) begin
      m_wc    <= dev_datain;
      m_steps <= 0;
    end
    if (instr == ENCT) begin
      if (cina) m_addr <= m_cr[2] ? m_addr - 8'd1 : m_addr + 8'd1;
      if (cinw) m_steps <= m_steps + 1;
    end
  end

  assign dev_address = m_addr;
  assign done        = done_en && (m_steps >= done_after);
  assign dev_oedata  = (instr == RDAC) || (instr == RDWC);
  assign dev_dataout = (instr == RDAC) ? m_addr :
                       (instr == RDWC) ? (m_wc ^ wc_corrupt) : 8'h00;

  // Memory responder: acks every ack_period-th cycle until the transfer is done.
  int cyc = 0;
  int ack_period = 1;
  always @(negedge clk) begin
    cyc++;
    mem_ack = !done && ((cyc % ack_period) == 0);
  end

  logic [7:0] beat_addr[$];
  int         step_pulses = 0;
  int         req_cycles  = 0;
  int         cpl_seen    = 0;
  logic       cpl_e;
  logic [8:0] cpl_b;

  always @(posedge clk) begin
    if (!rst) begin
      if (mem_req && mem_ack) beat_addr.push_back(mem_addr);
      if (cina && cinw) step_pulses++;
      if (mem_req) req_cycles++;
      if (cpl_valid) begin
        cpl_seen++;
        cpl_e = cpl_err;
        cpl_b = cpl_beats;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] beat(input int i);
    if (i < beat_addr.size()) return beat_addr[i];
    return 8'hxx;
  endfunction

  task automatic start_req(input logic [7:0] a, input logic [7:0] c,
                           input logic [1:0] m, input logic d);
    @(negedge clk);
    req_addr  = a;
    req_count = c;
    req_mode  = m;
    req_dec   = d;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_cpl(input int start, input int budget, input string tag);
    int n;
    n = 0;
    while (cpl_seen == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(cpl_seen - start), 32'd1);
  endtask

  logic [26:0] rst_vec;
  localparam logic [26:0] RST_EXP = {3'd1, 8'h00, 7'b0000001, 9'd0};
  int b0, s0, c0, r0, bad, n;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_count = '0;
    req_mode = '0; req_dec = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_vec = {instr, dev_datain, cina, cinw, mem_req, busy, cpl_valid, cpl_err, req_ready, cpl_beats};
    check("reset_outputs", 32'(rst_vec), 32'(RST_EXP));
    rst = 1'b0;

    // 1: four beats, incrementing, memory always ready
    done_en = 1'b1; done_after = 4; ack_period = 1;
    b0 = beat_addr.size(); s0 = step_pulses; c0 = cpl_seen;
    start_req(8'h10, 8'd4, 2'b01, 1'b0);
    check("t1_instr_wrcr", 32'(instr), 32'd0);
    check("t1_datain_cr", 32'(dev_datain), 32'h01);
    check("t1_busy_ready", 32'({busy, req_ready}), 32'b10);
    @(negedge clk);
    check("t1_instr_ldaddr", 32'({instr, dev_datain}), 32'h510);
    @(negedge clk);
    check("t1_instr_ldwc", 32'({instr, dev_datain}), 32'h604);
`ifdef AM2940_SEQ_READBACK_EN
    @(negedge clk);
    check("t1_instr_rdac", 32'(instr), 32'd3);
    @(negedge clk);
    check("t1_instr_rdwc", 32'(instr), 32'd2);
`endif
    @(negedge clk);
    check("t1_instr_enct", 32'({instr, mem_req}), 32'b1111);
    wait_cpl(c0, 60, "t1_cpl_seen");
    check("t1_addrs", 32'({beat(b0), beat(b0+1), beat(b0+2), beat(b0+3)}), 32'h10111213);
    check("t1_beats", 32'(beat_addr.size() - b0), 32'd4);
    check("t1_cpl", 32'({cpl_e, cpl_b}), 32'({1'b0, 9'd4}));
    @(negedge clk);
    check("t1_idle", 32'({busy, req_ready, instr}), 32'({2'b01, 3'd1}));

    // 2: three beats, decrementing, ack every third cycle
    done_after = 3; ack_period = 3;
    b0 = beat_addr.size(); s0 = step_pulses; c0 = cpl_seen;
    start_req(8'hFE, 8'd3, 2'b00, 1'b1);
    wait_cpl(c0, 80, "t2_cpl_seen");
    check("t2_addrs", 32'({beat(b0), beat(b0+1), beat(b0+2)}), 32'hFEFDFC);
    check("t2_steps", 32'(step_pulses - s0), 32'd3);
    check("t2_cpl", 32'({cpl_e, cpl_b}), 32'({1'b0, 9'd3}));

    // 3: count 0 means 256 words, address wraps
    done_after = 256; ack_period = 1;
    b0 = beat_addr.size(); c0 = cpl_seen;
    start_req(8'h80, 8'd0, 2'b00, 1'b0);
    wait_cpl(c0, 700, "t3_cpl_seen");
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (beat(b0 + i) !== 8'(8'h80 + i)) bad++;
    end
    check("t3_addr_seq", 32'(bad), 32'd0);
    check("t3_wrap", 32'({beat(b0+127), beat(b0+128)}), 32'hFF00);
    check("t3_cpl", 32'({cpl_e, cpl_b}), 32'({1'b0, 9'd256}));

    // 4: done never rises, watchdog at expected+1
    done_en = 1'b0;
    b0 = beat_addr.size(); s0 = step_pulses; c0 = cpl_seen;
    start_req(8'h20, 8'd2, 2'b00, 1'b0);
    wait_cpl(c0, 60, "t4_cpl_seen");
    check("t4_cpl", 32'({cpl_e, cpl_b}), 32'({1'b1, 9'd3}));
    check("t4_steps", 32'(step_pulses - s0), 32'd3);

    // 5: reset mid-RUN abandons without completion; new request still works
    done_en = 1'b1; done_after = 4;
    b0 = beat_addr.size(); c0 = cpl_seen;
    start_req(8'h40, 8'd4, 2'b00, 1'b0);
    n = 0;
    while (beat_addr.size() == b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t5_first_beat", 32'(beat_addr.size() - b0), 32'd1);
    @(negedge clk);
    check("t5_in_run", 32'({mem_req, instr}), 32'b1111);
    rst = 1'b1;
    #1;
    rst_vec = {instr, dev_datain, cina, cinw, mem_req, busy, cpl_valid, cpl_err, req_ready, cpl_beats};
    check("t5_reset_async", 32'(rst_vec), 32'(RST_EXP));
    @(negedge clk);
    rst_vec = {instr, dev_datain, cina, cinw, mem_req, busy, cpl_valid, cpl_err, req_ready, cpl_beats};
    check("t5_reset_held", 32'(rst_vec), 32'(RST_EXP));
    rst = 1'b0;
    @(negedge clk);
    check("t5_no_cpl", 32'(cpl_seen - c0), 32'd0);
    done_after = 1;
    b0 = beat_addr.size(); c0 = cpl_seen;
    start_req(8'h55, 8'd1, 2'b00, 1'b0);
    wait_cpl(c0, 40, "t5_new_cpl_seen");
    check("t5_new_cpl", 32'({cpl_e, cpl_b, beat(b0)}), 32'({1'b0, 9'd1, 8'h55}));

`ifdef AM2940_SEQ_READBACK_EN
    // 6: readback of word count returns 5 instead of 4
    done_after = 4; wc_corrupt = 8'h01;
    r0 = req_cycles; c0 = cpl_seen;
    start_req(8'h30, 8'd4, 2'b00, 1'b0);
    wait_cpl(c0, 40, "t6_cpl_seen");
    check("t6_cpl", 32'({cpl_e, cpl_b}), 32'({1'b1, 9'd0}));
    check("t6_no_mem_req", 32'(req_cycles - r0), 32'd0);
    wc_corrupt = 8'h00;
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/am2940_dma_sequencer.md
Name: am2940_dma_sequencer

Overview:
Initiator-side controller for the am2940 DMA address generator. It accepts one block-transfer request, programs the am2940 over its instr/datain bus, and then steps the address and word counters once per memory beat. It finishes when the am2940 raises done and reports a completion status. It sits between the system request queue and the am2940 instance, and drives the memory-side address handshake.

Parameters:
AW, 8, address/data width of the am2940 bus
CW, 9, beat-counter width (must hold 2**AW)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  transfer request valid
req_ready  out  1  high only in IDLE
req_addr  in  AW  start address
req_count  in  AW  word count; 0 means 2**AW words
req_mode  in  2  control-register mode bits CR[1:0]
req_dec  in  1  CR[2]: 1 = address decrements
instr  out  3  am2940 instruction
dev_datain  out  AW  data driven to am2940 datain
dev_dataout  in  AW  am2940 dataout
dev_oedata  in  1  am2940 dataout valid
dev_address  in  AW  am2940 address output
cina  out  1  address-counter carry-in (count enable)
cinw  out  1  word-counter carry-in (count enable)
done  in  1  am2940 word-count-done
mem_req  out  1  memory beat request
mem_addr  out  AW  beat address (= dev_address while mem_req)
mem_ack  in  1  memory accepts the beat
busy  out  1  high whenever state != IDLE
cpl_valid  out  1  one-cycle completion pulse
cpl_err  out  1  qualified by cpl_valid
cpl_beats  out  CW  beats issued, qualified by cpl_valid

Behaviour:
- Reset values: state IDLE; instr = RDCR (3'd1, side-effect-free); dev_datain = 0; cina = cinw = 0; mem_req = 0; busy = 0; cpl_valid = 0; cpl_err = 0; cpl_beats = 0; req_ready = 1.
- All outputs are registered. Reset asserted mid-transfer abandons the transfer immediately; there is no completion pulse.
- IDLE: a request is accepted on the clock edge where req_valid && req_ready. The request fields are captured and expected = (req_count==0) ? 2**AW : req_count.
- Programming states, one cycle each, in this order:
  - WR_CR: instr = WRCR (0), dev_datain = {0, req_dec, req_mode}.
  - LD_ADDR: instr = LDADDR (5), dev_datain = addr.
  - LD_WC: instr = LDWC (6), dev_datain = count.
  - Then RUN with instr = ENCT (7).
- RUN:
  - mem_req = 1, mem_addr = dev_address.
  - On an edge with mem_req && mem_ack: the beat counter increments, mem_req drops, and cina = cinw = 1 for exactly the next cycle (state STEP). mem_req then re-asserts.
  - The maximum rate is one beat every 2 cycles.
- done is sampled only in RUN, and only while mem_req is high and mem_ack is low. done && mem_ack together in the same cycle: the beat takes priority, and done is re-sampled afterwards.
- done seen → CPL.
  - cpl_valid pulses for one cycle.
  - cpl_beats = beat counter.
  - cpl_err = (beats != expected).
  - instr returns to RDCR.
  - Next state IDLE.
- Watchdog: if the beat counter reaches expected+1 without done, go to CPL with cpl_err = 1. The beat counter saturates and never wraps.
- A req_valid arriving while busy is ignored: req_ready stays low.

Optional Feature:
AM2940_SEQ_READBACK_EN
- Defined: two extra states are inserted after LD_WC.
  - RB_ADDR: instr = RDAC (3).
  - RB_WC: instr = RDWC (2).
  - Each state waits for dev_oedata and compares dev_dataout with the programmed value.
  - A mismatch skips RUN and goes to CPL with cpl_err = 1, cpl_beats = 0.
  - If dev_oedata is absent for 4 cycles, the result is treated as a mismatch.
- Undefined: the sequence goes LD_WC → RUN directly, and the readback logic is absent.

Decomposition:
- Package am2940_pkg holds:
  - the instruction enum (WRCR=0, RDCR=1, RDWC=2, RDAC=3, REINIT=4, LDADDR=5, LDWC=6, ENCT=7);
  - the control-register bit positions;
  - the sequencer state enum.
- Sub-module am2940_beat_ctr: saturating beat counter with clear, increment, compare-to-expected and overflow flag.

Test Plan:
1. addr=8'h10, count=4, inc, mem_ack always 1, model raises done after 4 steps → instr sequence 0,5,6,7; mem_addr 10,11,12,13; cpl_beats=4, cpl_err=0.
2. addr=8'hFE, count=3, dec, mem_ack every 3rd cycle → mem_addr FE,FD,FC; exactly 3 cina/cinw pulses; cpl_err=0.
3. count=0, done after 256 steps → cpl_beats=256, cpl_err=0; address wraps FF→00 without error.
4. count=2, model never raises done → watchdog at 3 beats; cpl_err=1, cpl_beats=3.
5. rst pulsed in RUN after 1 beat → next cycle all outputs at reset values, no cpl_valid; a new request is accepted afterwards.
6. With READBACK_EN, model returns wrong word count (5 vs 4) → no mem_req; cpl_err=1, cpl_beats=0.
